// File: rtl/minmax_cmp_sched_if.sv
// ============================================================================
// Module   : minmax_cmp_sched_if
// Purpose  : Sample-in / result-out handshake bundle for minmax_cmp_sched.
// Revision : 1.0  initial release
// ============================================================================
`default_nettype none

interface minmax_cmp_sched_if #(
  parameter int WIDTH = 5,
  parameter int CNT_W = 8
);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] in_data;
  logic             in_last;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] out_min;
  logic [WIDTH-1:0] out_max;
  logic [CNT_W-1:0] out_count;

  // Source and result consumer side
  modport master (
    output in_valid, in_data, in_last, out_ready,
    input  in_ready, out_valid, out_min, out_max, out_count
  );

  // Min/max tracker side
  modport slave (
    input  in_valid, in_data, in_last, out_ready,
    output in_ready, out_valid, out_min, out_max, out_count
  );
endinterface

`default_nettype wire

// File: rtl/minmax_cmp_sched.sv
// ============================================================================
// Module   : minmax_cmp_sched
// Purpose  : Streaming per-frame signed min/max/count tracker using one shared
//            less-than comparator scheduled over two cycles per sample.
// Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module minmax_cmp_sched #(
  parameter int WIDTH = 5,
  parameter int CNT_W = 8
) (
  input  wire                   clk,
  input  wire                   reset,
  minmax_cmp_sched_if.slave     bus
);

  localparam logic [CNT_W-1:0] c_CNT_MAX = {CNT_W{1'b1}};
  localparam logic [CNT_W-1:0] c_CNT_ONE = CNT_W'(1);

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_CMP_MIN = 2'd1,
    S_CMP_MAX = 2'd2,
    S_HOLD    = 2'd3
  } state_t;

  state_t           r_state;
  logic             r_first;
  logic             r_last;
  logic             r_out_valid;
  logic [WIDTH-1:0] r_sample;
  logic [WIDTH-1:0] r_min;
  logic [WIDTH-1:0] r_max;
  logic [CNT_W-1:0] r_count;

  logic [WIDTH-1:0] w_cmp_a;
  logic [WIDTH-1:0] w_cmp_b;
  logic             w_lt;
  logic             w_accept;

  // Sign bits differing decides the order outright; otherwise the magnitude
  // bits compare as unsigned. No subtraction, so no overflow corner cases.
  function automatic logic lt_signed(input logic [WIDTH-1:0] a,
                                     input logic [WIDTH-1:0] b);
    if (a[WIDTH-1] != b[WIDTH-1]) begin
      return a[WIDTH-1];
    end
    return (a[WIDTH-2:0] < b[WIDTH-2:0]);
  endfunction

  always_comb begin
    w_cmp_a = r_max;
    w_cmp_b = r_sample;
    if (r_state == S_CMP_MIN) begin
      w_cmp_a = r_sample;
      w_cmp_b = r_min;
    end
  end

  assign w_lt     = lt_signed(w_cmp_a, w_cmp_b);
  assign w_accept = bus.in_valid && (r_state == S_IDLE) && !reset;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state     <= S_IDLE;
      r_first     <= 1'b1;
      r_last      <= 1'b0;
      r_out_valid <= 1'b0;
      r_sample    <= '0;
      r_min       <= '0;
      r_max       <= '0;
      r_count     <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_accept) begin
            r_sample <= bus.in_data;
            r_last   <= bus.in_last;
            if (r_count != c_CNT_MAX) begin
              r_count <= r_count + c_CNT_ONE;
            end
            if (r_first) begin
              r_first <= 1'b0;
              r_min   <= bus.in_data;
              r_max   <= bus.in_data;
              if (bus.in_last) begin
                r_state     <= S_HOLD;
                r_out_valid <= 1'b1;
              end
            end else begin
              r_state <= S_CMP_MIN;
            end
          end
        end

        S_CMP_MIN: begin
          if (w_lt) begin
            r_min <= r_sample;
          end
          r_state <= S_CMP_MAX;
        end

        S_CMP_MAX: begin
          if (w_lt) begin
            r_max <= r_sample;
          end
          if (r_last) begin
            r_state     <= S_HOLD;
            r_out_valid <= 1'b1;
          end else begin
            r_state <= S_IDLE;
          end
        end

        S_HOLD: begin
          if (bus.out_ready) begin
            r_state     <= S_IDLE;
            r_out_valid <= 1'b0;
            r_first     <= 1'b1;
            r_count     <= '0;
          end
        end

        default: begin
          r_state <= S_IDLE;
        end
      endcase
    end
  end

  assign bus.in_ready  = (r_state == S_IDLE) && !reset;
  assign bus.out_valid = r_out_valid;
  assign bus.out_min   = r_min;
  assign bus.out_max   = r_max;
  assign bus.out_count = r_count;

endmodule

`default_nettype wire

// File: tb/tb_minmax_cmp_sched.sv
// ============================================================================
// Module   : tb_minmax_cmp_sched
// Purpose  : Randomized and directed self-checking bench for minmax_cmp_sched.
// Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_minmax_cmp_sched;

  localparam int WIDTH = 5;
  localparam int CNT_W = 8;
  localparam int CMAX  = (1 << CNT_W) - 1;

  logic clk = 1'b0;
  logic rst = 1'b1;

  minmax_cmp_sched_if #(.WIDTH(WIDTH), .CNT_W(CNT_W)) bus ();

  minmax_cmp_sched #(.WIDTH(WIDTH), .CNT_W(CNT_W)) dut (
    .clk   (clk),
    .reset (rst),
    .bus   (bus.slave)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;
  bit force_low = 1'b0;
  int ready_pct = 60;

  task automatic check(input string name, input int act, input int exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  function automatic int sx(input logic [WIDTH-1:0] v);
    return int'($signed(v));
  endfunction

  // ---------------- behavioural model ----------------
  int m_q[$];          // samples of the frame in progress
  int m_busy = 0;      // cycles the block is still busy comparing
  bit m_pend_last = 0;
  bit m_hold = 0;
  bit m_chk_zero = 0;

  always @(negedge clk) begin
    int mn, mx, cnt;
    if (m_chk_zero) begin
      check("rst_out_valid", int'(bus.out_valid), 0);
      check("rst_out_min",   sx(bus.out_min), 0);
      check("rst_out_max",   sx(bus.out_max), 0);
      check("rst_out_count", int'(bus.out_count), 0);
      m_chk_zero = 0;
    end
    if (rst) begin
      check("rst_in_ready", int'(bus.in_ready), 0);
      m_q.delete();
      m_busy = 0;
      m_pend_last = 0;
      m_hold = 0;
      m_chk_zero = 1;
    end else begin
      check("in_ready",  int'(bus.in_ready),  int'(!m_hold && m_busy == 0));
      check("out_valid", int'(bus.out_valid), int'(m_hold));
      if (m_hold) begin
        mn = m_q[0];
        mx = m_q[0];
        foreach (m_q[i]) begin
          if (m_q[i] < mn) mn = m_q[i];
          if (m_q[i] > mx) mx = m_q[i];
        end
        cnt = (m_q.size() > CMAX) ? CMAX : m_q.size();
        check("out_min",   sx(bus.out_min), mn);
        check("out_max",   sx(bus.out_max), mx);
        check("out_count", int'(bus.out_count), cnt);
        if (bus.out_ready) begin
          m_hold = 0;
          m_q.delete();
        end
      end else if (m_busy > 0) begin
        m_busy--;
        if (m_busy == 0 && m_pend_last) m_hold = 1;
      end else if (bus.in_valid) begin
        m_q.push_back(sx(bus.in_data));
        if (m_q.size() == 1) begin
          if (bus.in_last) m_hold = 1;
        end else begin
          m_busy = 2;
          m_pend_last = bus.in_last;
        end
      end
    end
  end

  // ---------------- consumer ----------------
  initial begin
    bus.out_ready = 1'b0;
    forever begin
      @(posedge clk);
      #1;
      bus.out_ready = force_low ? 1'b0 : ($urandom_range(0, 99) < ready_pct);
    end
  end

  // ---------------- source helpers ----------------
  task automatic send(input int v, input bit last);
    int t = 0;
    bus.in_valid = 1'b1;
    bus.in_data  = v[WIDTH-1:0];
    bus.in_last  = last;
    forever begin
      @(negedge clk);
      if (bus.in_ready && !rst) break;
      t++;
      if (t > 200) begin
        check("send_timeout", 0, 1);
        break;
      end
    end
    @(posedge clk);
    #1;
    bus.in_valid = 1'b0;
    bus.in_data  = WIDTH'($urandom);
    bus.in_last  = 1'($urandom);
  endtask

  task automatic wait_result(input string name, input int emin, input int emax, input int ecnt);
    int t = 0;
    forever begin
      @(negedge clk);
      if (bus.out_valid) break;
      t++;
      if (t > 1000) break;
    end
    check({name, "_valid"}, int'(bus.out_valid), 1);
    check({name, "_min"},   sx(bus.out_min), emin);
    check({name, "_max"},   sx(bus.out_max), emax);
    check({name, "_count"}, int'(bus.out_count), ecnt);
  endtask

  initial begin
    #(10 * 90000);
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  // ---------------- stimulus ----------------
  initial begin
    int extremes[4];
    int len, v, gap, t;
    extremes = '{-16, 15, 0, -1};
    bus.in_valid = 1'b0;
    bus.in_data  = '0;
    bus.in_last  = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    ready_pct = 100;

    // frame {3,-2,7,0}; last non-first sample: out_valid after the 3rd edge
    send(3, 0); send(-2, 0); send(7, 0); send(0, 1);
    check("t1_lat0", int'(bus.out_valid), 0);
    @(posedge clk); #1;
    check("t1_lat1", int'(bus.out_valid), 0);
    @(posedge clk); #1;
    check("t1_lat2", int'(bus.out_valid), 1);
    wait_result("t1", -2, 7, 4);
    check("t1_min_bits", int'(bus.out_min), 5'b11110);

    // overflow pairs, both orders
    send(-16, 0); send(15, 1);
    wait_result("t2a", -16, 15, 2);
    send(15, 0); send(-16, 1);
    wait_result("t2b", -16, 15, 2);

    // single-sample frame: valid right after the accept edge
    send(-5, 1);
    check("t3_lat", int'(bus.out_valid), 1);
    wait_result("t3", -5, -5, 1);

    // equal values
    send(4, 0); send(4, 0); send(4, 1);
    wait_result("t4", 4, 4, 3);

    // backpressure
    force_low = 1'b1;
    send(1, 0); send(2, 1);
    wait_result("t5", 1, 2, 2);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("t5_hold_valid", int'(bus.out_valid), 1);
      check("t5_hold_ready", int'(bus.in_ready), 0);
      check("t5_hold_min",   sx(bus.out_min), 1);
      check("t5_hold_max",   sx(bus.out_max), 2);
      check("t5_hold_count", int'(bus.out_count), 2);
    end
    force_low = 1'b0;
    t = 0;
    forever begin
      @(negedge clk);
      if (bus.out_ready) break;
      t++;
      if (t > 50) begin
        check("t5_release_timeout", 0, 1);
        break;
      end
    end
    @(posedge clk); #1;
    check("t5_idle_ready", int'(bus.in_ready), 1);
    check("t5_idle_valid", int'(bus.out_valid), 0);

    // reset while comparing
    send(9, 0); send(-9, 0);
    rst = 1'b1;
    check("t6_ready_in_rst", int'(bus.in_ready), 0);
    @(posedge clk); #1;
    check("t6_valid", int'(bus.out_valid), 0);
    check("t6_min",   sx(bus.out_min), 0);
    check("t6_max",   sx(bus.out_max), 0);
    check("t6_count", int'(bus.out_count), 0);
    @(posedge clk); #1;
    rst = 1'b0;
    send(2, 1);
    wait_result("t6", 2, 2, 1);

    // counter saturation; tracking continues past it
    for (int i = 0; i < 260; i++) begin
      send(((i * 7) % 32) - 16, i == 259);
    end
    wait_result("sat", -16, 15, 255);

    // randomized frames
    ready_pct = 60;
    for (int f = 0; f < 40; f++) begin
      len = $urandom_range(1, 6);
      for (int k = 0; k < len; k++) begin
        if ($urandom_range(0, 3) == 0) v = extremes[$urandom_range(0, 3)];
        else v = int'($urandom_range(0, 31)) - 16;
        send(v, k == len - 1);
        gap = $urandom_range(0, 2);
        if (gap > 0) begin
          repeat (gap) @(posedge clk);
          #1;
        end
      end
    end

    ready_pct = 100;
    repeat (20) @(posedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
